// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-step shift-add core, RNE rounding, fixed 26-cycle latency.
// Define FP_MUL_SUBNORM_EN to accept subnormal inputs; otherwise they are flushed to signed zero.
module fp_multiplier_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out/out_valid hold in DONE until out_ready is seen.
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3} special_t;

  state_t             state_q;
  special_t           special_q, special_d;
  logic [4:0]         cnt_q;
  logic               prep_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        ma_q, mb_q;
  logic [47:0]        mcand_q, prod_q, prod_d;
  logic [31:0]        out_q, result_d;
  logic               out_valid_q, in_ready_q;

  logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic [7:0]         ea_eff, eb_eff;
  logic [23:0]        ma_d, mb_d, ma_norm, mb_norm;
  logic [9:0]         exp_sum_d;
  logic signed [9:0]  exp_norm;

  logic               p47, guard, sticky, rnd_up;
  logic [22:0]        mant;
  logic [23:0]        m_rnd;
  logic signed [9:0]  e_fin;

  assign in_ready    = in_ready_q;
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign dbg_state_o = state_q;

`ifdef FP_MUL_SUBNORM_EN
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) found = 1'b1;
      else if (!found) n = n + 5'd1;
    end
    return n;
  endfunction

  logic [4:0] lza, lzb;
`endif

  always_comb begin
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
`ifdef FP_MUL_SUBNORM_EN
    a_zero = (a[30:23] == 8'd0) && (a[22:0] == 23'd0);
    b_zero = (b[30:23] == 8'd0) && (b[22:0] == 23'd0);
`else
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
`endif
    // Subnormals carry an effective exponent of 1 and no implicit one.
    ea_eff    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb_eff    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma_d      = {a[30:23] != 8'd0, a[22:0]};
    mb_d      = {b[30:23] != 8'd0, b[22:0]};
    exp_sum_d = {2'b00, ea_eff} + {2'b00, eb_eff} - 10'd127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) special_d = SP_NAN;
    else if (a_inf || b_inf)                                       special_d = SP_INF;
    else if (a_zero || b_zero)                                     special_d = SP_ZERO;
    else                                                           special_d = SP_NONE;
  end

  // Pre-normalisation used in the first MULT cycle so the core always sees a leading one.
  always_comb begin
`ifdef FP_MUL_SUBNORM_EN
    lza      = lzc24(ma_q);
    lzb      = lzc24(mb_q);
    ma_norm  = ma_q << lza;
    mb_norm  = mb_q << lzb;
    exp_norm = exp_q - $signed({5'd0, lza}) - $signed({5'd0, lzb});
`else
    ma_norm  = ma_q;
    mb_norm  = mb_q;
    exp_norm = exp_q;
`endif
    prod_d = prod_q + (mb_q[0] ? mcand_q : 48'd0);
  end

  always_comb begin
    p47    = prod_q[47];
    mant   = p47 ? prod_q[46:24] : prod_q[45:23];
    guard  = p47 ? prod_q[23]    : prod_q[22];
    sticky = p47 ? (|prod_q[22:0]) : (|prod_q[21:0]);
    rnd_up = guard & (sticky | mant[0]);
    m_rnd  = {1'b0, mant} + {23'd0, rnd_up};
    e_fin  = exp_q + $signed({9'd0, p47}) + $signed({9'd0, m_rnd[23]});
    case (special_q)
      SP_NAN:  result_d = 32'h7FC0_0000;
      SP_INF:  result_d = {sign_q, 8'hFF, 23'd0};
      SP_ZERO: result_d = {sign_q, 31'd0};
      default: begin
        if (e_fin >= 10'sd255)    result_d = {sign_q, 8'hFF, 23'd0};
        else if (e_fin <= 10'sd0) result_d = {sign_q, 31'd0};
        else                      result_d = {sign_q, e_fin[7:0], m_rnd[22:0]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      special_q   <= SP_NONE;
      cnt_q       <= 5'd0;
      prep_q      <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      ma_q        <= 24'd0;
      mb_q        <= 24'd0;
      mcand_q     <= 48'd0;
      prod_q      <= 48'd0;
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= MULT;
            in_ready_q <= 1'b0;
            prep_q     <= 1'b1;
            cnt_q      <= 5'd0;
            sign_q     <= a[31] ^ b[31];
            exp_q      <= exp_sum_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            special_q  <= special_d;
          end
        end
        MULT: begin
          if (prep_q) begin
            prep_q  <= 1'b0;
            mcand_q <= {24'd0, ma_norm};
            mb_q    <= mb_norm;
            exp_q   <= exp_norm;
            prod_q  <= 48'd0;
          end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_q << 1;
            mb_q    <= mb_q >> 1;
            if (cnt_q == 5'd23) begin
              cnt_q   <= 5'd0;
              state_q <= ROUND;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ROUND: begin
          out_q       <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Bench for fp_multiplier_seq: directed and random operands scored against a real-arithmetic reference.
module tb_fp_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

`ifdef FP_MUL_SUBNORM_EN
  localparam bit SUBNORM = 1'b1;
`else
  localparam bit SUBNORM = 1'b0;
`endif

  fp_multiplier_seq dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .dbg_state_o(dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: exact product in double precision, then rounded to single.
  function automatic real fp_val(input logic [31:0] x);
    int  e;
    real f;
    e = int'(x[30:23]);
    f = real'(int'(x[22:0]));
    if (e == 0) return f * (2.0 ** (-149));
    return (8388608.0 + f) * (2.0 ** (e - 150));
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, xn, yn, xi, yi, xz, yz, g, st;
    logic [63:0] pb;
    logic [22:0] mant;
    logic [23:0] mr;
    int          e;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:23] == 8'd0) && ((x[22:0] == 0) || !SUBNORM);
    yz = (y[30:23] == 8'd0) && ((y[22:0] == 0) || !SUBNORM);
    if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    pb   = $realtobits(fp_val(x) * fp_val(y));
    e    = int'(pb[62:52]) - 1023 + 127;
    mant = pb[51:29];
    g    = pb[28];
    st   = |pb[27:0];
    mr   = {1'b0, mant} + ((g && (st || mant[0])) ? 24'd1 : 24'd0);
    if (mr[23]) e++;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), mr[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 11))
      0: begin e = 8'd0; m = 23'd0; end
      1: begin e = 8'hFF; m = 23'd0; end
      2: begin e = 8'hFF; m = m | 23'd1; end
      3: begin e = 8'd0; m = m | 23'd1; end
      4: e = 8'($urandom_range(190, 254));
      5: e = 8'($urandom_range(1, 70));
      6: begin e = 8'($urandom_range(120, 134)); m = {m[22:18], 18'd0}; end
      default: e = 8'($urandom_range(60, 194));
    endcase
    return {s, e, m};
  endfunction

  // Driver: present one operand pair and record the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    int budget;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // Consumer back-pressure: 0 always ready, 1 random, 2 driven by the directed test.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard
  logic        pending = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else if (out_valid) begin
      if (!pending) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out %h, expected no result", out);
        end else begin
          check("result", out, exp_q.pop_front());
          check("latency", 32'(cyc - acc_q.pop_front()), 32'd26);
        end
        pending = 1'b1;
        held = out;
      end else begin
        check("hold_out", out, held);
      end
      check("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_ready) pending = 1'b0;
    end else if (pending) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid_dropped: got 0, expected 1");
      pending = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int hi_cnt;
    logic [31:0] x, y;
    // Reset values, then accept on the first edge after release.
    a = 32'h4000_0000;
    b = 32'h4040_0000;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", out, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'h40C0_0000);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    send(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    send(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    send(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
    send(32'h0040_0000, 32'h4000_0000, SUBNORM ? 32'h0080_0000 : 32'h0000_0000);
    send(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    send(32'h8000_0000, 32'h4040_0000, 32'h8000_0000);
    send(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    send(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
    drain();

    // Hold the result for 10 cycles in DONE.
    rdy_mode = 2;
    out_ready = 1'b0;
    send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    check("hold_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) @(negedge clk);
    check("hold_state", 32'(dbg_state), 32'd3);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_state", 32'(dbg_state), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    rdy_mode = 0;

    // Reset during MULT at count 10.
    send(32'h3FC0_0000, 32'h4040_0000, 32'h4090_0000);
    repeat (11) @(posedge clk);
    #2;
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_out", out, 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) hi_cnt++;
    end
    check("no_valid_after_rst", 32'(hi_cnt), 32'd0);
    send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    drain();

    // Random operands with random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      x = rand_fp();
      y = rand_fp();
      send(x, y, ref_mul(x, y));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rdy_mode = 0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
